// File: rtl/instruc_fetch_if.sv
// instruc_fetch_if: fetch-stage bus grouping control, instruction memory and IF/ID signals
interface instruc_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] instruc;
    logic [31:0] instrucAddress;
    logic [31:0] ifidInstruc;
    logic [31:0] ifidPC;
    logic        ifidValid;

    modport master (
        input  stall, redirect, redirectTarget, instruc,
        output instrucAddress, ifidInstruc, ifidPC, ifidValid
    );

    modport slave (
        output stall, redirect, redirectTarget, instruc,
        input  instrucAddress, ifidInstruc, ifidPC, ifidValid
    );
endinterface

// File: rtl/instruc_fetch.sv
// instruc_fetch: PC register, in-flight tracking and IF/ID register of the fetch stage.
// Optional redirect counter enabled by defining INSTRUC_FETCH_REDIRECT_COUNT_EN.
module instruc_fetch (
    input  logic                   clk,
    input  logic                   rst_n,
    instruc_fetch_if.master        bus
`ifdef INSTRUC_FETCH_REDIRECT_COUNT_EN
    ,
    output logic [15:0]            redirectCount
`endif
);
    logic [31:0] pc;
    logic [31:0] pc_in_flight;
    logic        mem_valid;
    logic [31:0] ifid_instruc;
    logic [31:0] ifid_pc;
    logic        ifid_valid;

    assign bus.instrucAddress = pc;
    assign bus.ifidInstruc    = ifid_instruc;
    assign bus.ifidPC         = ifid_pc;
    assign bus.ifidValid      = ifid_valid;

    // PC advance, in-flight tag and IF/ID load; redirect outranks stall and flushes both stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= '0;
            pc_in_flight <= '0;
            mem_valid    <= 1'b0;
            ifid_instruc <= '0;
            ifid_pc      <= '0;
            ifid_valid   <= 1'b0;
        end else begin
            pc           <= bus.redirect ? bus.redirectTarget : bus.stall ? pc : pc + 32'd1;
            pc_in_flight <= bus.stall ? pc_in_flight : pc;
            mem_valid    <= bus.redirect ? 1'b0 : bus.stall ? mem_valid : 1'b1;
            if (bus.redirect) begin
                ifid_instruc <= '0;
                ifid_valid   <= 1'b0;
            end else if (!bus.stall) begin
                ifid_instruc <= mem_valid ? bus.instruc : '0;
                ifid_pc      <= pc_in_flight;
                ifid_valid   <= mem_valid;
            end
        end
    end

`ifdef INSTRUC_FETCH_REDIRECT_COUNT_EN
    // Saturating count of taken redirects
    always_ff @(posedge clk) begin
        if (!rst_n)
            redirectCount <= '0;
        else if (bus.redirect && redirectCount != 16'hFFFF)
            redirectCount <= redirectCount + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instruc_fetch.sv
// tb_instruc_fetch: directed checks of the fetch stage against a one-edge-latency memory
module tb_instruc_fetch;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    instruc_fetch_if bus ();

`ifdef INSTRUC_FETCH_REDIRECT_COUNT_EN
    logic [15:0] redirect_count;
    instruc_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus.master), .redirectCount(redirect_count));
`else
    instruc_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
`endif

    always #5 clk = ~clk;

    // Memory returns mem[n] = n + 0x100 one edge after the address; output held while stalled
    always @(posedge clk) begin
        if (!bus.stall)
            bus.instruc <= bus.instrucAddress + 32'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc_exp);
        chk({tag, "_valid"}, {31'b0, bus.ifidValid}, 32'd1);
        chk({tag, "_pc"}, bus.ifidPC, pc_exp);
        chk({tag, "_instr"}, bus.ifidInstruc, pc_exp + 32'h100);
    endtask

    task automatic chk_flushed(input string tag);
        chk({tag, "_valid"}, {31'b0, bus.ifidValid}, 32'd0);
        chk({tag, "_instr"}, bus.ifidInstruc, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirectTarget = '0;
        bus.instruc = '0;
        repeat (2) step();
        chk("rst_addr", bus.instrucAddress, 32'd0);
        chk("rst_pc", bus.ifidPC, 32'd0);
        chk_flushed("rst");

        rst_n = 1'b1;
        step();
        chk("run1_addr", bus.instrucAddress, 32'd1);
        chk("run1_valid", {31'b0, bus.ifidValid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_ifid("run", i);
        end

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 32'd3);
            chk("stall_addr", bus.instrucAddress, 32'd5);
        end
        bus.stall = 1'b0;
        for (int i = 4; i < 7; i++) begin
            step();
            chk_ifid("release", i);
        end

        rst_n = 1'b0;
        step();
        chk("mid_rst_addr", bus.instrucAddress, 32'd0);
        chk_flushed("mid_rst");
        rst_n = 1'b1;
        step();
        chk("mid_rst_e1_valid", {31'b0, bus.ifidValid}, 32'd0);
        step();
        chk_ifid("mid_rst_e2", 32'd0);
        repeat (3) step();
        chk("pre_redirect_addr", bus.instrucAddress, 32'd5);

        bus.redirect = 1'b1;
        bus.redirectTarget = 32'h20;
        step();
        bus.redirect = 1'b0;
        chk("redir_addr", bus.instrucAddress, 32'h20);
        chk_flushed("redir_c1");
        step();
        chk_flushed("redir_c2");
        step();
        chk_ifid("redir_tgt", 32'h20);

        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirectTarget = 32'h0A;
        step();
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        chk("stred_addr", bus.instrucAddress, 32'h0A);
        chk_flushed("stred_c1");
        step();
        chk_flushed("stred_c2");
        step();
        chk_ifid("stred_tgt", 32'h0A);

        bus.redirect = 1'b1;
        bus.redirectTarget = 32'hFFFF_FFFF;
        step();
        bus.redirect = 1'b0;
        chk("wrap_addr0", bus.instrucAddress, 32'hFFFF_FFFF);
        step();
        chk("wrap_addr1", bus.instrucAddress, 32'd0);
        step();
        chk_ifid("wrap_top", 32'hFFFF_FFFF);
        chk("wrap_top_instr_val", bus.ifidInstruc, 32'h0000_00FF);
        step();
        chk_ifid("wrap_zero", 32'd0);

`ifdef INSTRUC_FETCH_REDIRECT_COUNT_EN
        chk("rcount", {16'b0, redirect_count}, 32'd3);
`endif
        rst_n = 1'b0;
        step();
        chk("end_rst_addr", bus.instrucAddress, 32'd0);
        chk("end_rst_valid", {31'b0, bus.ifidValid}, 32'd0);
`ifdef INSTRUC_FETCH_REDIRECT_COUNT_EN
        chk("rcount_rst", {16'b0, redirect_count}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
